gpio_serial_loader: RTL
=======================

// Module: gpio_serial_loader
// PURPOSE
//  Transmit end of the GPIO pad-configuration serial chain. Holds one PAD_CTRL_BITS config word per pad
//  in a local register file and, on request, shifts all words out on serial_clock/serial_data, then pulses serial_load.
//  Sits on the SoC side and drives serial_clock_in/serial_data_in/serial_load_in of the pad control chain.
// PARAMETERS
//  NUM_PADS       9       pads in the chain (chain length)
//  PAD_CTRL_BITS  12      config bits per pad
//  CFG_DEFAULT    12'hC00 reset value of every config word
//  CLK_DIV        4       mclk cycles per serial_clock half-period (>=1)
//  AUTO_START     1       1: one full load runs automatically after reset release
// PORTS
//  mclk          in   1                      system clock
//  reset         in   1                      asynchronous reset, active-high
//  cfg_wr_en     in   1                      write strobe for config register file
//  cfg_wr_addr   in   $clog2(NUM_PADS)       pad index to write
//  cfg_wr_data   in   PAD_CTRL_BITS          config word
//  start         in   1                      single-cycle request to transmit entire chain
//  busy          out  1                      transmission in progress
//  done          out  1                      one-cycle pulse, transmission complete
//  serial_clock  out  1                      chain shift clock
//  serial_data   out  1                      chain shift data
//  serial_load   out  1                      chain load strobe
// BEHAVIOUR
//  Reset: all words = CFG_DEFAULT; busy, done, serial_clock, serial_data, serial_load = 0; FSM = IDLE.
//  Reset mid-transfer: outputs drop to 0 immediately; serial_load never pulses for the aborted transfer.
//  Register file: write on cfg_wr_en only when FSM==IDLE; writes while busy are dropped;
//   cfg_wr_addr >= NUM_PADS is ignored.
//  Trigger: start in IDLE -> SHIFT next cycle; start while busy is ignored. AUTO_START=1 acts as a start
//   on the first mclk edge after reset deasserts.
//  Same-cycle cfg_wr_en and start in IDLE: the write commits and the transfer uses the new value.
//  Bit order: NBITS = NUM_PADS*PAD_CTRL_BITS. Pad NUM_PADS-1 first, pad 0 last; each word MSB first.
//   After NBITS shifts, pad k holds word k.
//  FSM: IDLE -> SHIFT -> GAP -> LOAD -> IDLE.
//   SHIFT: per bit, serial_data updates on entry to the low phase.
//    Low phase: serial_clock = 0 for CLK_DIV cycles. High phase: serial_clock = 1 for CLK_DIV cycles.
//    Data is stable for the whole bit period. Bit and pad counters advance at the end of the high phase.
//    After bit NBITS-1 -> GAP.
//   GAP: serial_clock = 0, serial_data = 0, for CLK_DIV cycles -> LOAD.
//   LOAD: serial_load = 1 for CLK_DIV cycles, serial_clock = 0 -> IDLE, with done = 1 for that one cycle.
//  busy = 1 from the cycle after start through the last LOAD cycle; busy = 0 in the done cycle.
//   Busy duration = 2*CLK_DIV*NBITS + 2*CLK_DIV cycles.
//  serial_clock, serial_data and serial_load are registered (glitch-free). serial_load and serial_clock
//   are never high together.
//  Counters: bit index wraps at PAD_CTRL_BITS-1 -> 0 with pad decrement. Divider counter wraps at CLK_DIV-1.
//  Register file is unchanged by transmission. Back-to-back starts re-send identical data.
// TESTING (NUM_PADS=2, PAD_CTRL_BITS=12, CLK_DIV=2, AUTO_START=0 unless noted)
//  1. Reset, then start -> 24 rising serial_clock edges sampling C00 (pad1) then C00 (pad0) MSB first;
//     busy high 100 cycles; done pulses once.
//  2. Write pad1=ABC, pad0=123, start -> bitstream 1010_1011_1100_0001_0010_0011.
//     Model 2-pad chain holds pad1=ABC, pad0=123 at load.
//  3. cfg_wr_en (pad0=FFF) while busy -> dropped; a second start re-sends the old value.
//  4. start and write pad0=5A5 in the same IDLE cycle -> transmitted pad0 = 5A5; start while busy has no effect.
//  5. Assert reset at bit 10 -> outputs 0 at once, no serial_load pulse, words back to C00.
//  6. AUTO_START=1, NUM_PADS=9 -> after reset release one load of 108 bits of C00 with no start;
//     serial_load high 4 cycles.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader
//   Transmit end of the GPIO pad-configuration serial chain. Keeps one
//   PAD_CTRL_BITS-wide config word per pad. On request it shifts every word
//   out on serial_clock/serial_data, then pulses serial_load. The last pad is
//   sent first and pad 0 last, with each word sent MSB first.
//
// Ports
//   mclk          in   system clock
//   reset         in   asynchronous reset, active-high
//   cfg_wr_en     in   register-file write strobe (honoured only while idle)
//   cfg_wr_addr   in   pad index to write (out-of-range indices ignored)
//   cfg_wr_data   in   config word
//   start         in   single-cycle request to transmit the whole chain
//   busy          out  transmission in progress
//   done          out  one-cycle pulse when the transmission completes
//   serial_clock  out  chain shift clock (registered)
//   serial_data   out  chain shift data (registered)
//   serial_load   out  chain load strobe (registered)

module gpio_serial_loader #(
   parameter int                       NUM_PADS      = 9,
   parameter int                       PAD_CTRL_BITS = 12,
   parameter logic [PAD_CTRL_BITS-1:0] CFG_DEFAULT   = 12'hC00,
   parameter int                       CLK_DIV       = 4,
   parameter bit                       AUTO_START    = 1'b1,
   localparam int                      AW            = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                     mclk,
   input  logic                     reset,
   input  logic                     cfg_wr_en,
   input  logic [AW-1:0]            cfg_wr_addr,
   input  logic [PAD_CTRL_BITS-1:0] cfg_wr_data,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   output logic                     serial_clock,
   output logic                     serial_data,
   output logic                     serial_load
);

   localparam int BW = (PAD_CTRL_BITS > 1) ? $clog2(PAD_CTRL_BITS) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(PAD_CTRL_BITS - 1);
   localparam logic [AW-1:0] PAD_LAST = AW'(NUM_PADS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP,
      LOAD
   } state_t;

   state_t                   state, state_n;
   logic [DW-1:0]            div, div_n;
   logic                     phase, phase_n;     // 0: low half, 1: high half
   logic [BW-1:0]            bit_cnt, bit_n;     // counts up; selects bit BIT_LAST-bit_cnt
   logic [AW-1:0]            pad, pad_n;         // counts down from PAD_LAST
   logic                     auto_pend;
   logic                     go;
   logic                     addr_ok;
   logic                     wr_ok;
   logic                     sclk_n, sdata_n, sload_n, done_n;

   logic [PAD_CTRL_BITS-1:0] words      [NUM_PADS];
   logic [PAD_CTRL_BITS-1:0] words_next [NUM_PADS];

   // Address range check only exists when the address field can hold
   // values beyond the last pad.
   if ((2 ** AW) > NUM_PADS) begin : g_addr_chk
      assign addr_ok = (32'(cfg_wr_addr) < NUM_PADS);
   end else begin : g_addr_all
      assign addr_ok = 1'b1;
   end

   assign wr_ok = cfg_wr_en && addr_ok && (state == IDLE);
   assign go    = start || auto_pend;
   assign busy  = (state != IDLE);

   // Write-through view of the register file. The first transmitted bit is
   // read from this view, so a write in the same cycle as start is sent.
   always_comb begin
      for (int unsigned i = 0; i < NUM_PADS; i++) begin
         words_next[i] = words[i];
      end
      if (wr_ok) begin
         words_next[cfg_wr_addr] = cfg_wr_data;
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_PADS; i++) begin
            words[i] <= CFG_DEFAULT;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_PADS; i++) begin
            words[i] <= words_next[i];
         end
      end
   end

   // Automatic start fires on the first clock edge after reset release.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         auto_pend <= AUTO_START;
      end else begin
         auto_pend <= 1'b0;
      end
   end

   // Next-state logic. The serial outputs are derived from the next state
   // so that the flops below drive the pins directly.
   always_comb begin
      state_n = state;
      div_n   = div;
      phase_n = phase;
      bit_n   = bit_cnt;
      pad_n   = pad;
      done_n  = 1'b0;

      case (state)
         IDLE: begin
            if (go) begin
               state_n = SHIFT;
               div_n   = '0;
               phase_n = 1'b0;
               bit_n   = '0;
               pad_n   = PAD_LAST;
            end
         end

         SHIFT: begin
            if (div == DIV_LAST) begin
               div_n = '0;
               if (!phase) begin
                  phase_n = 1'b1;
               end else begin
                  phase_n = 1'b0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_n = '0;
                     if (pad == '0) begin
                        state_n = GAP;
                     end else begin
                        pad_n = pad - 1'b1;
                     end
                  end else begin
                     bit_n = bit_cnt + 1'b1;
                  end
               end
            end else begin
               div_n = div + 1'b1;
            end
         end

         GAP: begin
            if (div == DIV_LAST) begin
               div_n   = '0;
               state_n = LOAD;
            end else begin
               div_n = div + 1'b1;
            end
         end

         LOAD: begin
            if (div == DIV_LAST) begin
               div_n   = '0;
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               div_n = div + 1'b1;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase

      sclk_n  = (state_n == SHIFT) && phase_n;
      sload_n = (state_n == LOAD);
      sdata_n = 1'b0;
      if (state_n == SHIFT) begin
         sdata_n = words_next[pad_n][BIT_LAST - bit_n];
      end
   end

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         div          <= '0;
         phase        <= 1'b0;
         bit_cnt      <= '0;
         pad          <= '0;
         done         <= 1'b0;
         serial_clock <= 1'b0;
         serial_data  <= 1'b0;
         serial_load  <= 1'b0;
      end else begin
         state        <= state_n;
         div          <= div_n;
         phase        <= phase_n;
         bit_cnt      <= bit_n;
         pad          <= pad_n;
         done         <= done_n;
         serial_clock <= sclk_n;
         serial_data  <= sdata_n;
         serial_load  <= sload_n;
      end
   end

endmodule
